// File: rtl/mult_div_pkg.sv
// Shared types and constants for mult_div_unit: operation codes, FSM states, iteration count.
package mult_div_pkg;

    localparam int unsigned Width    = 32;
    localparam int unsigned NumIter  = 32;
    localparam int unsigned CntWidth = 5;

    localparam logic [CntWidth-1:0] LastIter = CntWidth'(NumIter - 1);

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StFinish = 2'b10
    } state_e;

    function automatic logic op_is_signed(logic [1:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic op_is_div(logic [1:0] op);
        return (op == OpDivu) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/sign_magnitude32.sv
// Conditional two's-complement negation with a carry-in, so two instances chain into a 64-bit
// negate (low half carry_i = 1, high half carry_i = "low half was zero").
module sign_magnitude32 (
    input  logic        negate_i,
    input  logic        carry_i,
    input  logic [31:0] value_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = (value_i ^ {32{negate_i}}) + {31'd0, negate_i & carry_i};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with Hi/Lo result registers, 32 steps per operation.
// Define MULT_DIV_UNIT_DIV_EN to include the restoring divider (Op 10/11).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = Width
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    mq_q, mq_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;

    logic                op_ok, accept;
    logic                sign_a, sign_b;
    logic [WIDTH-1:0]    mag_a, mag_b;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH-1:0]    step_acc, step_mq;
    logic                hi_carry;
    logic [WIDTH-1:0]    res_hi, res_lo;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic                div_q, div_d;
    logic                dbz_q, dbz_d;
    logic [WIDTH:0]      div_shift;

    assign op_ok = 1'b1;
`else
    assign op_ok = !op_is_div(Op);
`endif

    assign sign_a = op_is_signed(Op) & OperandA[WIDTH-1];
    assign sign_b = op_is_signed(Op) & OperandB[WIDTH-1];
    assign accept = Start && op_ok && (state_q != StRun);

    sign_magnitude32 u_mag_a (
        .negate_i (sign_a),
        .carry_i  (1'b1),
        .value_i  (OperandA),
        .result_o (mag_a)
    );

    sign_magnitude32 u_mag_b (
        .negate_i (sign_b),
        .carry_i  (1'b1),
        .value_i  (OperandB),
        .result_o (mag_b)
    );

    // acc holds the product high half / partial remainder; mq holds multiplier / quotient bits.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        step_acc = mul_sum[WIDTH:1];
        step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
        div_shift = {acc_q, mq_q[WIDTH-1]};
        if (div_q) begin
            if (div_shift >= {1'b0, b_q}) begin
                step_acc = WIDTH'(div_shift - {1'b0, b_q});
                step_mq  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_mq  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
        hi_carry = (step_mq == '0);
`ifdef MULT_DIV_UNIT_DIV_EN
        // Quotient and remainder are negated independently, not as one 64-bit value.
        if (div_q) begin
            hi_carry = 1'b1;
        end
`endif
    end

    sign_magnitude32 u_fix_lo (
        .negate_i (neg_lo_q),
        .carry_i  (1'b1),
        .value_i  (step_mq),
        .result_o (res_lo)
    );

    sign_magnitude32 u_fix_hi (
        .negate_i (neg_hi_q),
        .carry_i  (hi_carry),
        .value_i  (step_acc),
        .result_o (res_hi)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_q    <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_q    <= div_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
`ifdef MULT_DIV_UNIT_DIV_EN
        div_d    = div_q;
        dbz_d    = dbz_q;
`endif
        unique case (state_q)
            StIdle, StFinish: begin
                state_d = StIdle;
                if (accept) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mq_d     = mag_a;
                    b_d      = mag_b;
                    neg_lo_d = sign_a ^ sign_b;
                    // Remainder follows the dividend; a product follows both operands.
                    neg_hi_d = op_is_div(Op) ? sign_a : (sign_a ^ sign_b);
`ifdef MULT_DIV_UNIT_DIV_EN
                    div_d    = op_is_div(Op);
                    dbz_d    = (OperandB == '0);
`endif
                end
            end
            StRun: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StFinish;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
`ifdef MULT_DIV_UNIT_DIV_EN
                    if (div_q && dbz_q) begin
                        lo_d = '1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Busy = (state_q == StRun);
        Done = (state_q == StFinish);
        Hi   = hi_q;
        Lo   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed vectors.
// Divide vectors run only when MULT_DIV_UNIT_DIV_EN is defined; otherwise Op[1]=1 must be ignored.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int start_cyc = 0;
    bit cmp_en    = 1'b0;

`ifdef MULT_DIV_UNIT_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Op       (Op),
        .OperandA (A),
        .OperandB (B),
        .Busy     (Busy),
        .Done     (Done),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    // Expected {Hi, Lo} straight from the arithmetic definition of each operation.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint unsigned ua, ub;
        longint          sa, sb;
        int              ia, ib, q, r;
        case (op)
            2'b00: begin
                ua = 64'(a);
                ub = 64'(b);
                return ua * ub;
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                ia = $signed(a);
                ib = $signed(b);
                q  = ia / ib;
                r  = ia % ib;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Timeline model: an accepted Start yields the result 32 edges later, Done for one cycle.
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;
    logic        m_done = 1'b0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_pend;
                    m_done       <= 1'b1;
                end
            end else if (Start && (DivEn || !Op[1])) begin
                m_left <= 32;
                m_pend <= ref_result(Op, A, B);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_en && Reset_n) begin
            check("busy", 64'(Busy), 64'(m_left != 0));
            check("done", 64'(Done), 64'(m_done));
            check("hi", 64'(Hi), 64'(m_hi));
            check("lo", 64'(Lo), 64'(m_lo));
        end
    end

    // Called at a negedge; returns at the negedge after the Start-sampling edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1 start_cyc = cyc;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Latency counts edges from the Start-sampling edge through the edge sampling Done, inclusive.
    task automatic wait_done(output int lat);
        int guard = 0;
        while (Done !== 1'b1 && guard < 60) begin
            @(negedge Clk);
            guard++;
        end
        lat = cyc - start_cyc + 2;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int lat;
        start_op(op, a, b);
        wait_done(lat);
        check({name, " latency"}, 64'(lat), 64'd34);
        check({name, " hi"}, 64'(Hi), 64'(exp_hi));
        check({name, " lo"}, 64'(Lo), 64'(exp_lo));
    endtask

    initial begin
        int lat;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Op      = 2'b00;
        A       = '0;
        B       = '0;
        repeat (3) @(negedge Clk);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset hi", 64'(Hi), 64'd0);
        check("reset lo", 64'(Lo), 64'd0);
        Reset_n = 1'b1;
        cmp_en  = 1'b1;

        run_op("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult -7x6", 2'b01, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6);
        run_op("mult min sq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op("multu mixed", 2'b00, 32'h00010000, 32'h00020003, 32'h2, 32'h00030000);
        run_op("mult -1x-1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
`ifdef MULT_DIV_UNIT_DIV_EN
        run_op("div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu 100/0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        run_op("div min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("divu 1000/7", 2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);
        run_op("div -100/0", 2'b11, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF);
`else
        Start = 1'b1;
        Op    = 2'b10;
        A     = 32'd100;
        B     = 32'd0;
        repeat (3) begin
            @(negedge Clk);
            check("divu ignored busy", 64'(Busy), 64'd0);
            check("divu ignored hi", 64'(Hi), 64'd0);
            check("divu ignored lo", 64'(Lo), 64'd1);
        end
        Start = 1'b0;
`endif

        // Start pulsed mid-RUN with new operands must be ignored.
        @(negedge Clk);
        start_op(2'b00, 32'd3, 32'd5);
        repeat (4) @(negedge Clk);
        Start = 1'b1;
        Op    = 2'b01;
        A     = 32'd100;
        B     = 32'd100;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(lat);
        check("midrun latency", 64'(lat), 64'd34);
        check("midrun lo", 64'(Lo), 64'd15);
        repeat (3) @(negedge Clk);
        check("midrun no relaunch", 64'(Busy), 64'd0);

        // Reset in the middle of RUN aborts without a result; Start right after release works.
        start_op(2'b00, 32'hFFFFFFFF, 32'd2);
        repeat (9) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("abort busy", 64'(Busy), 64'd0);
        check("abort done", 64'(Done), 64'd0);
        check("abort hi", 64'(Hi), 64'd0);
        check("abort lo", 64'(Lo), 64'd0);
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        start_op(2'b00, 32'd3, 32'd4);
        wait_done(lat);
        check("post reset latency", 64'(lat), 64'd34);
        check("post reset lo", 64'(Lo), 64'd12);
        check("post reset hi", 64'(Hi), 64'd0);

        // Start held through FINISH launches the next operation with no idle cycle.
        repeat (2) @(negedge Clk);
        Start = 1'b1;
        Op    = 2'b00;
        A     = 32'd2;
        B     = 32'd3;
        @(posedge Clk);
        #1 start_cyc = cyc;
        wait_done(lat);
        check("b2b first latency", 64'(lat), 64'd34);
        check("b2b first lo", 64'(Lo), 64'd6);
        A = 32'd5;
        B = 32'd7;
        @(posedge Clk);
        #1 start_cyc = cyc;
        @(negedge Clk);
        check("b2b no idle", 64'(Busy), 64'd1);
        Start = 1'b0;
        wait_done(lat);
        check("b2b second latency", 64'(lat), 64'd34);
        check("b2b second lo", 64'(Lo), 64'd35);

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
